// File: rtl/mtrx_slice_streamer_if.sv
// Element stream from the slice streamer to a systolic-array operand port.
// The producer drives valid/data/last/done and the consumer drives ready.
interface mtrx_slice_streamer_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  valid;
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
    logic                  done;
    logic                  ready;

    modport master (
        output valid,
        output data,
        output last,
        output done,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  last,
        input  done,
        output ready
    );
endinterface

// File: rtl/mtrx_slice_streamer.sv
// Matrix-slice source for one systolic-array operand.
// Walks a configured list of slices (base, stride, length, count) through a
// synchronous RAM and streams the returned elements through a small FIFO,
// marking the last element of every slice and pulsing done after the final
// element of the job has been accepted.
module mtrx_slice_streamer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int LEN_WIDTH  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  s_clk,
    input  logic                  s_rst_n,
    input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
    input  logic [LEN_WIDTH-1:0]  cfg_slice_len,
    input  logic [ADDR_WIDTH-1:0] cfg_slice_stride,
    input  logic [LEN_WIDTH-1:0]  cfg_slice_num,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    mtrx_slice_streamer_if.master m_slice
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;
    localparam int CNT_W = PTR_W + 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_t;

    state_t state;
    state_t state_next;

    // Job configuration captured at start so mid-job cfg changes are harmless.
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  num_q;
    logic [ADDR_WIDTH-1:0] stride_q;

    // Read walk position.
    logic [ADDR_WIDTH-1:0] slice_base;
    logic [LEN_WIDTH-1:0]  elem_idx;
    logic [LEN_WIDTH-1:0]  slice_idx;

    // The one read that can be outstanding with its tags.
    logic rd_pend;
    logic pend_last;
    logic pend_job_last;

    // Output buffer.
    logic [DATA_WIDTH-1:0] fifo_data     [FIFO_DEPTH];
    logic                  fifo_last     [FIFO_DEPTH];
    logic                  fifo_job_last [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [OCC_W-1:0]      occ;

    logic done_q;

    logic             cfg_ok;
    logic             fifo_valid;
    logic             push;
    logic             pop;
    logic [CNT_W-1:0] committed;
    logic             elem_last;
    logic             slice_last;
    logic             issue;
    logic             final_hs;
    logic             accept_job;
    logic             empty_job;

    assign cfg_ok     = (cfg_slice_len != '0) && (cfg_slice_num != '0);
    assign fifo_valid = (occ != '0);
    assign pop        = fifo_valid && m_slice.ready;
    assign push       = rd_pend;
    // Entries already owed to the FIFO; the entry leaving this cycle is free.
    assign committed  = CNT_W'(occ) + CNT_W'(rd_pend) - CNT_W'(pop);
    assign elem_last  = (elem_idx == len_q - LEN_WIDTH'(1));
    assign slice_last = (slice_idx == num_q - LEN_WIDTH'(1));
    assign issue      = (state == ST_RUN) && !abort && (committed < CNT_W'(FIFO_DEPTH));
    assign final_hs   = pop && fifo_job_last[rd_ptr];
    assign accept_job = (state == ST_IDLE) && start && !abort && cfg_ok;
    assign empty_job  = (state == ST_IDLE) && start && !abort && !cfg_ok;

    // State register.
    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: abort always returns to idle; drain ends on the job's last beat.
    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (start && cfg_ok) state_next = ST_RUN;
                ST_RUN:   if (issue && elem_last && slice_last) state_next = ST_DRAIN;
                ST_DRAIN: if (final_hs) state_next = ST_IDLE;
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    // Capture the job and advance the element/slice walk on every issued read.
    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            len_q      <= '0;
            num_q      <= '0;
            stride_q   <= '0;
            slice_base <= '0;
            elem_idx   <= '0;
            slice_idx  <= '0;
        end else begin
            if (accept_job) begin
                len_q      <= cfg_slice_len;
                num_q      <= cfg_slice_num;
                stride_q   <= cfg_slice_stride;
                slice_base <= cfg_base_addr;
                elem_idx   <= '0;
                slice_idx  <= '0;
            end
            if (issue) begin
                if (elem_last) begin
                    elem_idx   <= '0;
                    slice_base <= slice_base + stride_q;
                    slice_idx  <= slice_idx + LEN_WIDTH'(1);
                end else begin
                    elem_idx <= elem_idx + LEN_WIDTH'(1);
                end
            end
        end
    end

    // Track the outstanding read; abort drops whatever comes back.
    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            rd_pend       <= 1'b0;
            pend_last     <= 1'b0;
            pend_job_last <= 1'b0;
        end else begin
            rd_pend       <= issue;
            pend_last     <= elem_last;
            pend_job_last <= elem_last && slice_last;
        end
    end

    // Buffer storage; contents are only observed while the entry is occupied.
    always_ff @(posedge s_clk) begin
        if (push) begin
            fifo_data[wr_ptr]     <= mem_rd_data;
            fifo_last[wr_ptr]     <= pend_last;
            fifo_job_last[wr_ptr] <= pend_job_last;
        end
    end

    // Buffer pointers and occupancy; simultaneous push and pop both take effect.
    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            occ <= occ + OCC_W'(push) - OCC_W'(pop);
        end
    end

    // Done pulses the cycle after the job's final beat, or after an empty job request.
    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            done_q <= 1'b0;
        end else begin
            done_q <= !abort && (empty_job || ((state == ST_DRAIN) && final_hs));
        end
    end

    assign busy          = (state != ST_IDLE);
    assign mem_rd_en     = issue;
    assign mem_rd_addr   = slice_base + ADDR_WIDTH'(elem_idx);
    assign m_slice.valid = fifo_valid;
    assign m_slice.data  = fifo_valid ? fifo_data[rd_ptr] : '0;
    assign m_slice.last  = fifo_valid ? fifo_last[rd_ptr] : 1'b0;
    assign m_slice.done  = done_q;

endmodule

// File: tb/tb_mtrx_slice_streamer.sv
// Bench for mtrx_slice_streamer: a synchronous RAM model feeds the DUT, and
// every job is compared against the address/element list derived directly
// from base + slice*stride + element arithmetic.
module tb_mtrx_slice_streamer;

    logic        s_clk = 1'b0;
    logic        s_rst_n = 1'b0;
    logic [15:0] cfg_base_addr = '0;
    logic [15:0] cfg_slice_len = '0;
    logic [15:0] cfg_slice_stride = '0;
    logic [15:0] cfg_slice_num = '0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        busy;
    logic        mem_rd_en;
    logic [15:0] mem_rd_addr;
    logic [7:0]  mem_rd_data = '0;

    mtrx_slice_streamer_if #(.DATA_WIDTH(8)) s_if ();

    mtrx_slice_streamer #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(16),
        .LEN_WIDTH(16),
        .FIFO_DEPTH(4)
    ) dut (
        .s_clk            (s_clk),
        .s_rst_n          (s_rst_n),
        .cfg_base_addr    (cfg_base_addr),
        .cfg_slice_len    (cfg_slice_len),
        .cfg_slice_stride (cfg_slice_stride),
        .cfg_slice_num    (cfg_slice_num),
        .start            (start),
        .abort            (abort),
        .busy             (busy),
        .mem_rd_en        (mem_rd_en),
        .mem_rd_addr      (mem_rd_addr),
        .mem_rd_data      (mem_rd_data),
        .m_slice          (s_if)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int start_cyc = 0;
    int rdy_mode = 0;

    logic [15:0] exp_addr[$];
    logic [7:0]  exp_data[$];
    logic        exp_last[$];
    logic [15:0] got_addr[$];
    logic [7:0]  got_data[$];
    logic        got_last[$];
    int          rd_cycs[$];
    int          hs_cycs[$];
    int          done_cycs[$];

    logic       prev_stall = 1'b0;
    logic [8:0] prev_beat = '0;

    // Clock.
    always #5 s_clk = ~s_clk;

    // Cycle counter.
    initial forever begin
        @(posedge s_clk);
        cyc++;
    end

    function automatic logic [7:0] ram_val(input logic [15:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5A;
    endfunction

    // Synchronous RAM: data appears the cycle after the read strobe.
    always @(posedge s_clk) begin
        if (mem_rd_en) mem_rd_data <= ram_val(mem_rd_addr);
    end

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Consumer ready pattern, chosen per job.
    initial begin
        s_if.ready = 1'b1;
        forever begin
            int rel;
            @(posedge s_clk);
            #1;
            rel = cyc - start_cyc;
            case (rdy_mode)
                0: s_if.ready = 1'b1;
                1: s_if.ready = rel[0];
                2: s_if.ready = 1'($urandom_range(0, 1));
                default: s_if.ready = (rel >= 6 && rel < 11) ? 1'b0 : rel[0];
            endcase
        end
    end

    // Monitor, sampled mid-cycle: reads, handshakes, done pulses, stall stability.
    initial forever begin
        @(negedge s_clk);
        if (s_rst_n) begin
            if (prev_stall) begin
                check_output("stall_valid", 32'(s_if.valid), 32'd1);
                check_output("stall_beat", 32'({s_if.last, s_if.data}), 32'(prev_beat));
            end
            if (mem_rd_en) begin
                got_addr.push_back(mem_rd_addr);
                rd_cycs.push_back(cyc);
            end
            if (s_if.valid && s_if.ready) begin
                got_data.push_back(s_if.data);
                got_last.push_back(s_if.last);
                hs_cycs.push_back(cyc);
            end
            if (s_if.done) done_cycs.push_back(cyc);
            prev_stall = s_if.valid && !s_if.ready && !abort;
            prev_beat  = {s_if.last, s_if.data};
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic build_expected(input int base, input int len, input int stride, input int num);
        logic [15:0] a;
        exp_addr.delete();
        exp_data.delete();
        exp_last.delete();
        for (int s = 0; s < num; s++) begin
            for (int e = 0; e < len; e++) begin
                a = 16'(base + s * stride + e);
                exp_addr.push_back(a);
                exp_data.push_back(ram_val(a));
                exp_last.push_back(e == len - 1);
            end
        end
    endtask

    // Pulse start with a configuration, then scramble cfg_* to prove it was latched.
    task automatic apply_stimulus(input int base, input int len, input int stride, input int num);
        got_addr.delete();
        got_data.delete();
        got_last.delete();
        rd_cycs.delete();
        hs_cycs.delete();
        done_cycs.delete();
        @(posedge s_clk);
        #1;
        cfg_base_addr    = 16'(base);
        cfg_slice_len    = 16'(len);
        cfg_slice_stride = 16'(stride);
        cfg_slice_num    = 16'(num);
        start            = 1'b1;
        start_cyc        = cyc;
        @(posedge s_clk);
        #1;
        start            = 1'b0;
        cfg_base_addr    = 16'($urandom);
        cfg_slice_len    = 16'($urandom_range(1, 9));
        cfg_slice_stride = 16'($urandom);
        cfg_slice_num    = 16'($urandom_range(1, 9));
    endtask

    task automatic compare_beats(input string tag, input bit full);
        int n;
        if (full) check_output({tag, "_beats"}, 32'(got_data.size()), 32'(exp_data.size()));
        n = (got_data.size() < exp_data.size()) ? got_data.size() : exp_data.size();
        for (int i = 0; i < n; i++) begin
            check_output({tag, "_data"}, 32'(got_data[i]), 32'(exp_data[i]));
            check_output({tag, "_last"}, 32'(got_last[i]), 32'(exp_last[i]));
        end
    endtask

    task automatic run_job(input int base, input int len, input int stride, input int num,
                           input int mode, input bit timing, input string tag);
        int n;
        rdy_mode = mode;
        build_expected(base, len, stride, num);
        apply_stimulus(base, len, stride, num);
        @(negedge s_clk);
        check_output({tag, "_busy"}, 32'(busy), 32'd1);
        @(posedge s_clk);
        #1;
        start = 1'b1;
        @(posedge s_clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 3000 && done_cycs.size() == 0; i++) @(posedge s_clk);
        check_output({tag, "_done_seen"}, 32'(done_cycs.size() > 0), 32'd1);
        repeat (4) @(posedge s_clk);
        @(negedge s_clk);
        check_output({tag, "_done_count"}, 32'(done_cycs.size()), 32'd1);
        check_output({tag, "_busy_end"}, 32'(busy), 32'd0);
        compare_beats(tag, 1'b1);
        check_output({tag, "_reads"}, 32'(got_addr.size()), 32'(exp_addr.size()));
        n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
        for (int i = 0; i < n; i++) check_output({tag, "_addr"}, 32'(got_addr[i]), 32'(exp_addr[i]));
        if (done_cycs.size() > 0 && hs_cycs.size() > 0)
            check_output({tag, "_done_cyc"}, 32'(done_cycs[0]), 32'(hs_cycs[hs_cycs.size() - 1] + 1));
        if (timing && rd_cycs.size() > 0 && hs_cycs.size() > 0) begin
            check_output({tag, "_first_rd"}, 32'(rd_cycs[0]), 32'(start_cyc + 1));
            check_output({tag, "_first_valid"}, 32'(hs_cycs[0]), 32'(start_cyc + 3));
            check_output({tag, "_b2b"}, 32'(hs_cycs[hs_cycs.size() - 1] - hs_cycs[0]),
                         32'(exp_data.size() - 1));
        end
    endtask

    initial begin
        // Reset state.
        s_rst_n = 1'b0;
        repeat (3) @(posedge s_clk);
        @(negedge s_clk);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_rd_en", 32'(mem_rd_en), 32'd0);
        check_output("rst_rd_addr", 32'(mem_rd_addr), 32'd0);
        check_output("rst_valid", 32'(s_if.valid), 32'd0);
        check_output("rst_data", 32'(s_if.data), 32'd0);
        check_output("rst_last", 32'(s_if.last), 32'd0);
        check_output("rst_done", 32'(s_if.done), 32'd0);
        @(posedge s_clk);
        #1;
        s_rst_n = 1'b1;

        run_job(16'h0000, 4, 16'h0004, 2, 0, 1'b1, "t1");
        run_job(16'h0100, 3, 16'h0010, 3, 0, 1'b0, "t2");
        run_job(16'h0000, 4, 16'h0004, 2, 3, 1'b0, "t3");
        run_job(16'h0000, 4, 16'h0004, 2, 1, 1'b0, "t3b");
        run_job(16'hFFFE, 4, 16'h0000, 1, 2, 1'b0, "t4");

        // Empty jobs: no reads, no beats, done the next cycle.
        for (int z = 0; z < 2; z++) begin
            rdy_mode = 0;
            apply_stimulus(16'h0040, (z == 0) ? 0 : 5, 16'h0008, (z == 0) ? 3 : 0);
            repeat (4) @(posedge s_clk);
            @(negedge s_clk);
            check_output("t5_reads", 32'(got_addr.size()), 32'd0);
            check_output("t5_beats", 32'(got_data.size()), 32'd0);
            check_output("t5_done_count", 32'(done_cycs.size()), 32'd1);
            if (done_cycs.size() > 0)
                check_output("t5_done_cyc", 32'(done_cycs[0]), 32'(start_cyc + 1));
            check_output("t5_busy", 32'(busy), 32'd0);
        end

        // Abort around beat 5 of 8.
        rdy_mode = 0;
        build_expected(16'h0000, 4, 16'h0004, 2);
        apply_stimulus(16'h0000, 4, 16'h0004, 2);
        for (int i = 0; i < 200 && got_data.size() < 5; i++) @(posedge s_clk);
        check_output("t6_reach5", 32'(got_data.size() >= 5), 32'd1);
        @(posedge s_clk);
        #1;
        abort = 1'b1;
        @(posedge s_clk);
        #1;
        abort = 1'b0;
        @(negedge s_clk);
        check_output("t6_valid_drop", 32'(s_if.valid), 32'd0);
        check_output("t6_busy", 32'(busy), 32'd0);
        repeat (20) @(posedge s_clk);
        @(negedge s_clk);
        check_output("t6_no_done", 32'(done_cycs.size()), 32'd0);
        check_output("t6_le8", 32'(got_data.size() <= 8), 32'd1);
        compare_beats("t6_prefix", 1'b0);
        run_job(16'h0200, 3, 16'h0020, 2, 0, 1'b0, "t6_after");

        // Reset asserted mid-job.
        rdy_mode = 0;
        apply_stimulus(16'h0300, 4, 16'h0004, 2);
        for (int i = 0; i < 200 && got_data.size() < 3; i++) @(posedge s_clk);
        @(posedge s_clk);
        #3;
        s_rst_n = 1'b0;
        #1;
        check_output("t7_valid", 32'(s_if.valid), 32'd0);
        check_output("t7_busy", 32'(busy), 32'd0);
        check_output("t7_rd_en", 32'(mem_rd_en), 32'd0);
        repeat (2) @(posedge s_clk);
        #1;
        s_rst_n = 1'b1;
        repeat (10) @(posedge s_clk);
        @(negedge s_clk);
        check_output("t7_no_done", 32'(done_cycs.size()), 32'd0);
        run_job(16'h0400, 2, 16'h0100, 3, 2, 1'b0, "t7_after");

        // Randomised jobs, biased towards the top of the address space.
        for (int r = 0; r < 8; r++) begin
            int base;
            base = (r % 2 == 0) ? int'($urandom_range(16'hFFF0, 16'hFFFF)) : int'($urandom_range(0, 16'hFFFF));
            run_job(base, int'($urandom_range(1, 5)), int'($urandom_range(0, 16'hFFFF)),
                    int'($urandom_range(1, 3)), int'($urandom_range(0, 3)), 1'b0, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
